// File: rtl/ccsds_tx_pkg.sv
// Shared constants and types for the CCSDS TX chain: ASM word/length,
// default codeblock length and the ASM inserter FSM state type.
package ccsds_tx_pkg;

  localparam logic [31:0] CCSDS_ASM_WORD   = 32'h1ACFFC1D;
  localparam int          CCSDS_ASM_BITS   = 32;
  localparam int          CCSDS_FRAME_BITS = 10200;

  typedef enum logic [1:0] {ASM_IDLE, ASM_SYNC, ASM_DATA} asm_state_e;

endpackage

// File: rtl/ccsds_asm_inserter.sv
// Bit-serial ASM inserter: prefixes each FRAME_BITS randomized codeblock with
// the ASM and restarts the scrambler. Optional macro: CCSDS_ASM_UNDERRUN_CNT_EN.
module ccsds_asm_inserter
  import ccsds_tx_pkg::*;
#(
  parameter logic [31:0] ASM_WORD   = CCSDS_ASM_WORD,
  parameter int          ASM_BITS   = CCSDS_ASM_BITS,
  parameter int          FRAME_BITS = CCSDS_FRAME_BITS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        scr_init_o,
  output logic        data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sof_o,
  output logic [1:0]  state_o
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt_o,
  output logic        underrun_o
`endif
);

  localparam int AW = (ASM_BITS > 1) ? $clog2(ASM_BITS) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [AW-1:0] ASM_START = AW'((ASM_BITS > 1) ? ASM_BITS - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  asm_state_e    state_q, state_d;
  logic [AW-1:0] asm_cnt_q, asm_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          data_q, data_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          adv;

  // Both sides use valid/ready: a beat moves on a clock edge where valid and
  // ready are both high; valid never drops and data never changes while the
  // beat is offered but not yet taken.
  assign adv = !valid_q || ready_i;

  always_comb begin
    state_d    = state_q;
    asm_cnt_d  = asm_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    ready_o    = 1'b0;
    scr_init_o = 1'b1;
    case (state_q)
      ASM_IDLE: begin
        if (adv) begin
          if (valid_i) begin
            data_d    = ASM_WORD[ASM_BITS-1];
            valid_d   = 1'b1;
            sof_d     = 1'b1;
            asm_cnt_d = ASM_START;
            bit_cnt_d = '0;
            if (ASM_BITS == 1) state_d = ASM_DATA;
            else               state_d = ASM_SYNC;
          end else begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
          end
        end
      end
      ASM_SYNC: begin
        if (adv) begin
          data_d  = ASM_WORD[asm_cnt_q];
          valid_d = 1'b1;
          sof_d   = 1'b0;
          if (asm_cnt_q == '0) begin
            state_d   = ASM_DATA;
            bit_cnt_d = '0;
          end else begin
            asm_cnt_d = asm_cnt_q - 1'b1;
          end
        end
      end
      ASM_DATA: begin
        // Keep the seed loaded while the last ASM bit is still stalled.
        scr_init_o = (bit_cnt_q == '0) && !adv;
        ready_o    = adv;
        if (adv) begin
          if (valid_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            sof_d   = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = ASM_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
          end
        end
      end
      default: state_d = ASM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ASM_IDLE;
      asm_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_cnt_q <= asm_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign state_o = state_q;

`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  assign underrun_o = (state_q == ASM_DATA) && adv && !valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underrun_cnt_q <= '0;
    end else if (underrun_o && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_ccsds_asm_inserter.sv
// Bench for ccsds_asm_inserter with FRAME_BITS=16: scenario table, output
// scoreboard, in-bench CCSDS randomizer, and a mid-frame reset sequence.
module tb_ccsds_asm_inserter;
  import ccsds_tx_pkg::*;

  localparam int FB = 16;
  localparam int AB = 32;

  typedef struct {
    int          ready_mode;   // 0 always, 1 toggle, 2 stall last ASM bit
    int          gap_after;
    int          gap_len;
    int          n_frames;
    logic [15:0] pattern;
    int          scramble;
    int          exp_scr_low;  // -1: not checked
    int          exp_bubbles;
  } scen_t;

  logic        clk, rst_i, data_i, valid_i, ready_i;
  logic        ready_o, scr_init_o, data_o, valid_o, sof_o;
  logic [1:0]  dbg_state;
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
  logic        underrun_o;
`endif

  ccsds_asm_inserter #(.FRAME_BITS(FB)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .scr_init_o(scr_init_o), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .sof_o(sof_o), .state_o(dbg_state)
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
    , .underrun_cnt_o(underrun_cnt_o), .underrun_o(underrun_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_q[$];
  logic [31:0] asm_word = 32'h1ACFFC1D;
  scen_t       cur;
  int          cyc, fed, total, beats, pops, pushed_frames;
  int          gap_left, stall_left, scr_low, bubbles;
  logic        seen, prev_hold, prev_data, prev_sof;
  logic [7:0]  lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic init_scen(input scen_t s);
    cur           = s;
    fed           = 0;
    total         = s.n_frames * FB;
    beats         = s.n_frames * (AB + FB);
    pops          = 0;
    pushed_frames = 0;
    gap_left      = 0;
    stall_left    = (s.ready_mode == 2) ? 4 : 0;
    scr_low       = 0;
    bubbles       = 0;
    seen          = 1'b0;
    prev_hold     = 1'b0;
    lfsr          = 8'hFF;
  endtask

  // driver: one clock of stimulus, output scoreboard and input acceptance
  task automatic drive_cycle();
    logic [1:0] e;
    logic       stalling;
    @(posedge clk);
    #1;
    cyc++;
    stalling = 1'b0;
    case (cur.ready_mode)
      1: ready_i = cyc[0];
      2: begin
        if (pops == AB - 1 && stall_left > 0) begin
          ready_i = 1'b0;
          stall_left--;
          stalling = 1'b1;
        end else begin
          ready_i = 1'b1;
        end
      end
      default: ready_i = 1'b1;
    endcase
    if (gap_left > 0) begin
      valid_i = 1'b0;
      gap_left--;
    end else if (fed < total) begin
      valid_i = 1'b1;
      data_i  = (cur.scramble != 0) ? lfsr[7] : cur.pattern[15 - (fed % FB)];
      if ((fed % FB) == 0 && pushed_frames == fed / FB) begin
        for (int i = AB - 1; i >= 0; i--) exp_q.push_back({(i == AB - 1), asm_word[i]});
        pushed_frames++;
      end
    end else begin
      valid_i = 1'b0;
    end
    #1;
    if (valid_o) seen = 1'b1;
    else if (seen && pops < beats) bubbles++;
    if (prev_hold) begin
      check("hold valid_o", valid_o, 1);
      check("hold data_o", data_o, prev_data);
      check("hold sof_o", sof_o, prev_sof);
    end
    prev_hold = valid_o && !ready_i;
    prev_data = data_o;
    prev_sof  = sof_o;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra beat: got data_o=%0b with nothing expected (cycle %0d)", data_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("data_o beat", data_o, e[0]);
        check("sof_o beat", sof_o, e[1]);
        pops++;
      end
    end
    if (stalling) begin
      check("stall ready_o", ready_o, 0);
      check("stall scr_init_o", scr_init_o, 1);
    end
    if (!scr_init_o) scr_low++;
    if (valid_i && ready_o) begin
      exp_q.push_back({1'b0, (cur.scramble != 0) ? cur.pattern[15 - (fed % FB)] : data_i});
      fed++;
      if (cur.gap_len > 0 && (fed % FB) == cur.gap_after) gap_left = cur.gap_len;
      if (cur.scramble != 0) lfsr = {lfsr[6:0], lfsr[0] ^ lfsr[2] ^ lfsr[4] ^ lfsr[7]};
    end
    if (scr_init_o) lfsr = 8'hFF;
  endtask

  task automatic run_scen(input scen_t s, input string tag);
    int budget;
    int uc0;
    init_scen(s);
    uc0 = 0;
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
    uc0 = int'(underrun_cnt_o);
`endif
    budget = 0;
    while ((pops < beats || fed < total) && budget < 2000) begin
      drive_cycle();
      budget++;
    end
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d beats expected %0d", tag, pops, beats);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " drained valid_o"}, valid_o, 0);
    check({tag, " leftover expected beats"}, exp_q.size(), 0);
    check({tag, " output beats"}, pops, beats);
    if (s.exp_scr_low >= 0) check({tag, " scr_init_o low cycles"}, scr_low, s.exp_scr_low);
    check({tag, " bubbles"}, bubbles, s.exp_bubbles);
    if (s.ready_mode == 2) check({tag, " stall applied"}, stall_left, 0);
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
    check({tag, " underrun count"}, int'(underrun_cnt_o) - uc0, s.exp_bubbles);
`endif
    exp_q.delete();
  endtask

  scen_t tbl[5];

  initial begin
    tbl[0] = '{0, 0, 0, 2, 16'h0000, 0, 32, 0};  // back-to-back zero frames
    tbl[1] = '{1, 0, 0, 1, 16'hA5C3, 0, -1, 0};  // toggling ready_i
    tbl[2] = '{0, 6, 3, 1, 16'h3C5A, 0, 19, 3};  // underrun after bit 5
    tbl[3] = '{2, 0, 0, 1, 16'h9B61, 0, 16, 0};  // stall on last ASM bit
    tbl[4] = '{0, 0, 0, 2, 16'hFF48, 1, 32, 0};  // scrambler chained, zero data

    cyc     = 0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = 1'b0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_o", data_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset sof_o", sof_o, 0);
    check("reset ready_o", ready_o, 0);
    check("reset scr_init_o", scr_init_o, 1);
    check("reset state", dbg_state, ASM_IDLE);
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
    check("reset underrun_cnt_o", underrun_cnt_o, 0);
`endif
    rst_i = 1'b0;

    for (int t = 0; t < 5; t++) run_scen(tbl[t], $sformatf("scen%0d", t));

    // reset while bit 9 of a frame is being offered
    begin
      scen_t rs;
      int    budget;
      rs = '{0, 0, 0, 1, 16'hD2B7, 0, 16, 0};
      init_scen(rs);
      budget = 0;
      while (fed < 9 && budget < 500) begin
        drive_cycle();
        budget++;
      end
      check("pre-reset bits accepted", fed, 9);
      @(posedge clk);
      #1;
      check("pre-reset state", dbg_state, ASM_DATA);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      #1;
      check("post-reset valid_o", valid_o, 0);
      check("post-reset sof_o", sof_o, 0);
      check("post-reset scr_init_o", scr_init_o, 1);
      check("post-reset ready_o", ready_o, 0);
      check("post-reset state", dbg_state, ASM_IDLE);
`ifdef CCSDS_ASM_UNDERRUN_CNT_EN
      check("post-reset underrun_cnt_o", underrun_cnt_o, 0);
`endif
      exp_q.delete();
      run_scen(rs, "after-reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
